// File: rtl/mdu_div_ctrl.sv
// mdu_div_ctrl
// Multi-cycle radix-2 restoring divide controller and pipeline stall
// scheduler. Serves DIV/DIVU from EX and returns {remainder, quotient}.
// The operation runs for DATA_W iterations, one per cycle. A zero divisor
// is short-cut through BYZERO and returns zero.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   start_i        EX divide request, held until ready_o
//   signed_div_i   1 = DIV (signed), 0 = DIVU; sampled in IDLE
//   opdata1_i      dividend, sampled in IDLE
//   opdata2_i      divisor, sampled in IDLE
//   annul_i        abort the current operation (flush)
//   stallreq_id_i  ID stage stall request
//   result_o       {remainder, quotient}, valid while ready_o = 1
//   ready_o        result valid, one cycle per operation
//   stall_o        stall vector {wb, mem, ex, id, if, pc}
module mdu_div_ctrl #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned CNT_W   = 6,
   parameter int unsigned STALL_W = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   input  logic                annul_i,
   input  logic                stallreq_id_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o,
   output logic [STALL_W-1:0]  stall_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BYZERO,
      S_BUSY,
      S_DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] dvd_q;   // dividend shifts out the top while quotient bits enter at the bottom
   logic [DATA_W-1:0] dvs;
   logic [DATA_W-1:0] prem;
   logic              qneg;
   logic              rneg;
   logic [DATA_W:0]   trial;
   logic [DATA_W-1:0] abs1;
   logic [DATA_W-1:0] abs2;
   logic [DATA_W-1:0] rem_out;
   logic [DATA_W-1:0] quo_out;

   // The partial remainder is always below 2^(DATA_W-1) before the last
   // step, so dropping its MSB on the shift loses nothing.
   always_comb begin
      trial = {1'b0, prem[DATA_W-2:0], dvd_q[DATA_W-1]} - {1'b0, dvs};
   end

   always_comb begin
      abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
      abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
   end

   always_comb begin
      state_nxt = state;
      if (annul_i) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  state_nxt = (opdata2_i == '0) ? S_BYZERO : S_BUSY;
               end
            end
            S_BYZERO: state_nxt = S_DONE;
            S_BUSY: begin
               if (cnt == CNT_W'(DATA_W - 1)) begin
                  state_nxt = S_DONE;
               end
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= '0;
         dvd_q <= '0;
         dvs   <= '0;
         prem  <= '0;
         qneg  <= 1'b0;
         rneg  <= 1'b0;
      end else if (annul_i) begin
         cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_i && (opdata2_i != '0)) begin
                  dvd_q <= abs1;
                  dvs   <= abs2;
                  prem  <= '0;
                  cnt   <= '0;
                  qneg  <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                  rneg  <= signed_div_i & opdata1_i[DATA_W-1];
               end
            end
            S_BYZERO: begin
               dvd_q <= '0;
               prem  <= '0;
               qneg  <= 1'b0;
               rneg  <= 1'b0;
               cnt   <= '0;
            end
            S_BUSY: begin
               if (trial[DATA_W]) begin
                  prem <= {prem[DATA_W-2:0], dvd_q[DATA_W-1]};
               end else begin
                  prem <= trial[DATA_W-1:0];
               end
               dvd_q <= {dvd_q[DATA_W-2:0], ~trial[DATA_W]};
               cnt   <= cnt + CNT_W'(1);
            end
            default: begin
               cnt <= '0;
            end
         endcase
      end
   end

   always_comb begin
      rem_out  = rneg ? (~prem + 1'b1) : prem;
      quo_out  = qneg ? (~dvd_q + 1'b1) : dvd_q;
      ready_o  = (state == S_DONE) && !annul_i;
      result_o = ready_o ? {rem_out, quo_out} : '0;
   end

   always_comb begin
      stall_o = '0;
      if (start_i && !ready_o && !annul_i) begin
         stall_o[3:0] = '1;
      end else if (stallreq_id_i) begin
         stall_o[2:0] = '1;
      end
   end

endmodule

// File: tb/tb_mdu_div_ctrl.sv
module tb_mdu_div_ctrl;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        annul_i;
   logic        stallreq_id_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic [5:0]  stall_o;

   typedef struct {
      logic [63:0] res;
      int          lat;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   mdu_div_ctrl #(.DATA_W(32), .CNT_W(6), .STALL_W(6)) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start_i),
      .signed_div_i  (signed_div_i),
      .opdata1_i     (opdata1_i),
      .opdata2_i     (opdata2_i),
      .annul_i       (annul_i),
      .stallreq_id_i (stallreq_id_i),
      .result_o      (result_o),
      .ready_o       (ready_o),
      .stall_o       (stall_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Issue one divide with start_i held until ready_o; the expected result
   // and latency go into the scoreboard and are popped when ready_o appears.
   task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] rem, input logic [31:0] quo,
                          input int lat, input logic sreq);
      exp_t e;
      int   cyc;
      logic done;
      e.res = {rem, quo};
      e.lat = lat;
      q.push_back(e);
      @(posedge clk);
      #1;
      signed_div_i  = sgn;
      opdata1_i     = a;
      opdata2_i     = b;
      start_i       = 1'b1;
      stallreq_id_i = sreq;
      cyc  = 1;
      done = 1'b0;
      while (!done && cyc <= 100) begin
         @(negedge clk);
         if (ready_o) begin
            e = q.pop_front();
            chk("latency", 64'(cyc), 64'(e.lat));
            chk("result", result_o, e.res);
            chk("stall_ready", {58'd0, stall_o}, sreq ? 64'h07 : 64'h00);
            done = 1'b1;
         end else begin
            chk("stall_busy", {58'd0, stall_o}, 64'h0f);
            @(posedge clk);
            #1;
            cyc++;
         end
      end
      chk("timeout", {63'd0, done}, 64'd1);
      if (!done && q.size() > 0) void'(q.pop_front());
      @(posedge clk);
      #1;
      start_i       = 1'b0;
      stallreq_id_i = 1'b0;
      @(negedge clk);
      chk("ready_drop", {63'd0, ready_o}, 64'd0);
      chk("result_idle", result_o, 64'd0);
   endtask

   initial begin
      logic seen;
      rst           = 1'b0;
      start_i       = 1'b0;
      signed_div_i  = 1'b0;
      opdata1_i     = '0;
      opdata2_i     = '0;
      annul_i       = 1'b0;
      stallreq_id_i = 1'b0;
      #2;
      chk("rst_ready", {63'd0, ready_o}, 64'd0);
      chk("rst_result", result_o, 64'd0);
      chk("rst_stall", {58'd0, stall_o}, 64'd0);
      #10 rst = 1'b1;

      // Unsigned and signed divides, including the wrap case.
      run_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 34, 1'b0);
      run_div(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 34, 1'b0);
      run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 34, 1'b0);
      run_div(1'b0, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 34, 1'b0);
      run_div(1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 34, 1'b0);
      run_div(1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 34, 1'b0);

      // Divide by zero.
      run_div(1'b0, 32'd55, 32'd0, 32'd0, 32'd0, 3, 1'b0);
      run_div(1'b1, 32'hFFFFFFF0, 32'd0, 32'd0, 32'd0, 3, 1'b0);

      // ID stall request concurrent with a busy divide.
      run_div(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3, 34, 1'b1);

      // Annul during BUSY (overall cycle 11 = 10th BUSY cycle).
      @(posedge clk);
      #1;
      signed_div_i = 1'b0;
      opdata1_i    = 32'd1000;
      opdata2_i    = 32'd3;
      start_i      = 1'b1;
      for (int i = 1; i < 11; i++) begin
         @(posedge clk);
         #1;
      end
      annul_i = 1'b1;
      #1;
      chk("annul_stall", {58'd0, stall_o}, 64'd0);
      chk("annul_ready", {63'd0, ready_o}, 64'd0);
      @(posedge clk);
      #1;
      annul_i = 1'b0;
      start_i = 1'b0;
      seen    = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ready_o) seen = 1'b1;
      end
      chk("annul_no_ready", {63'd0, seen}, 64'd0);
      run_div(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 34, 1'b0);

      // Asynchronous reset in the middle of BUSY.
      @(posedge clk);
      #1;
      opdata1_i = 32'd50;
      opdata2_i = 32'd5;
      start_i   = 1'b1;
      for (int i = 0; i < 5; i++) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("arst_ready", {63'd0, ready_o}, 64'd0);
      chk("arst_result", result_o, 64'd0);
      chk("arst_stall_ex", {58'd0, stall_o}, 64'h0f);
      start_i       = 1'b0;
      stallreq_id_i = 1'b1;
      #1;
      chk("arst_stall_id", {58'd0, stall_o}, 64'h07);
      @(negedge clk);
      #2;
      rst           = 1'b1;
      stallreq_id_i = 1'b0;
      @(negedge clk);
      chk("arst_idle_ready", {63'd0, ready_o}, 64'd0);
      run_div(1'b0, 32'd50, 32'd5, 32'd0, 32'd10, 34, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
